// File: rtl/downward_timer.sv
// downward_timer: programmable down-counting timer.
// Loads a start value, decrements once per enable tick and flags terminal
// count on reaching zero. On terminal count it reloads (periodic mode) or
// stops (one-shot mode). The period is load_value+1 enabled ticks.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        pulse: load load_value and (re)start counting
//   stop         pulse: abort counting, return to IDLE
//   en           tick enable; one decrement per enabled cycle in RUN
//   auto_reload  1 = periodic, 0 = one-shot; sampled at terminal count
//   load_value   start/reload value
//   count        current counter value (registered)
//   busy         high while in RUN (registered)
//   tc           one-cycle terminal-count strobe (registered)
//   done         sticky one-shot completion flag (registered)
module downward_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q,  busy_d;
    logic             tc_q,    tc_d;
    logic             done_q,  done_d;

    // State and registered-output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Priority within a cycle: stop > start > en.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    count_d = load_value;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    count_d = load_value;
                end else if (en) begin
                    if (count_q != '0) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        // Zero is the terminal event, so the decrement never wraps.
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = load_value;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    count_d = load_value;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered flags follow the next state so they align with count and tc.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        count  = count_q;
        busy   = busy_q;
        tc     = tc_q;
        done   = done_q;
    end

endmodule

// File: tb/tb_downward_timer.sv
module tb_downward_timer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, start, stop, en, auto_reload;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         busy, tc, done;

    int tests_run = 0;
    int tests_failed = 0;

    downward_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .auto_reload (auto_reload),
        .load_value  (load_value),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst, st, sp, e, ar;
        logic [W-1:0] lv;
        logic [W-1:0] exp_count;
        logic         exp_busy, exp_tc, exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic rst, logic st, logic sp, logic e, logic ar,
                                logic [W-1:0] lv, logic [W-1:0] c, logic b, logic t, logic d);
        vec_t v;
        v.name = name; v.rst = rst; v.st = st; v.sp = sp; v.e = e; v.ar = ar; v.lv = lv;
        v.exp_count = c; v.exp_busy = b; v.exp_tc = t; v.exp_done = d;
        vecs.push_back(v);
    endfunction

    // Drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic rst, input logic st, input logic sp, input logic e,
                        input logic ar, input logic [W-1:0] lv);
        @(negedge clk);
        reset = rst; start = st; stop = sp; en = e; auto_reload = ar; load_value = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] c, input logic b,
                         input logic t, input logic d);
        tests_run++;
        if (count !== c || busy !== b || tc !== t || done !== d) begin
            tests_failed++;
            $display("FAIL %s: got count=%0d busy=%b tc=%b done=%b, expected count=%0d busy=%b tc=%b done=%b",
                     name, count, busy, tc, done, c, b, t, d);
        end
    endtask

    initial begin
        int exp_c;
        int ticks;
        reset = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; auto_reload = 1'b0; load_value = '0;

        //   name          rst st sp en ar  lv   count busy tc done
        add("reset",        1, 0, 0, 0, 0,  0,   0,  0, 0, 0);
        add("idle_en",      0, 0, 0, 1, 0,  9,   0,  0, 0, 0);
        // one-shot, load 3
        add("os_start",     0, 1, 0, 0, 0,  3,   3,  1, 0, 0);
        add("os_en1",       0, 0, 0, 1, 0,  3,   2,  1, 0, 0);
        add("os_en2",       0, 0, 0, 1, 0,  3,   1,  1, 0, 0);
        add("os_en3",       0, 0, 0, 1, 0,  3,   0,  1, 0, 0);
        add("os_tc",        0, 0, 0, 1, 0,  3,   0,  0, 1, 1);
        add("os_after1",    0, 0, 0, 1, 0,  3,   0,  0, 0, 1);
        add("os_after2",    0, 0, 0, 1, 1,  3,   0,  0, 0, 1);
        // periodic, load 2 (start from DONE clears done)
        add("per_start",    0, 1, 0, 0, 1,  2,   2,  1, 0, 0);
        add("per_t1",       0, 0, 0, 1, 1,  2,   1,  1, 0, 0);
        add("per_t2",       0, 0, 0, 1, 1,  2,   0,  1, 0, 0);
        add("per_t3_tc",    0, 0, 0, 1, 1,  2,   2,  1, 1, 0);
        add("per_t4",       0, 0, 0, 1, 1,  2,   1,  1, 0, 0);
        add("per_t5",       0, 0, 0, 1, 1,  2,   0,  1, 0, 0);
        add("per_t6_tc",    0, 0, 0, 1, 1,  2,   2,  1, 1, 0);
        add("per_t7",       0, 0, 0, 1, 1,  2,   1,  1, 0, 0);
        add("per_t8",       0, 0, 0, 1, 1,  2,   0,  1, 0, 0);
        add("per_t9_tc",    0, 0, 0, 1, 1,  6,   6,  1, 1, 0);
        add("per_hold",     0, 0, 0, 0, 1,  2,   6,  1, 0, 0);
        add("per_stop",     0, 0, 1, 1, 1,  2,   6,  0, 0, 0);
        // restart and stop, load 10
        add("rs_start",     0, 1, 0, 0, 0, 10,  10,  1, 0, 0);
        add("rs_t1",        0, 0, 0, 1, 0, 10,   9,  1, 0, 0);
        add("rs_t2",        0, 0, 0, 1, 0, 10,   8,  1, 0, 0);
        add("rs_t3",        0, 0, 0, 1, 0, 10,   7,  1, 0, 0);
        add("rs_t4",        0, 0, 0, 1, 0, 10,   6,  1, 0, 0);
        add("rs_restart",   0, 1, 0, 1, 0,  7,   7,  1, 0, 0);
        add("rs_stop_en",   0, 0, 1, 1, 0,  3,   7,  0, 0, 0);
        add("rs_idle_en",   0, 0, 0, 1, 0,  3,   7,  0, 0, 0);
        // priority: stop+start in RUN
        add("pr_start",     0, 1, 0, 0, 0,  5,   5,  1, 0, 0);
        add("pr_stopstart", 0, 1, 1, 1, 0,  9,   5,  0, 0, 0);
        add("pr_idle_ss",   0, 1, 1, 0, 0,  9,   5,  0, 0, 0);
        // start beats a terminal condition
        add("st_load0",     0, 1, 0, 0, 0,  0,   0,  1, 0, 0);
        add("st_vs_tc",     0, 1, 0, 1, 0,  1,   1,  1, 0, 0);
        add("st_dec",       0, 0, 0, 1, 0,  1,   0,  1, 0, 0);
        add("st_tc",        0, 0, 0, 1, 0,  1,   0,  0, 1, 1);
        // start from DONE reloads; stop from DONE clears
        add("dn_start",     0, 1, 0, 0, 0,  4,   4,  1, 0, 0);
        add("dn_reload0",   0, 1, 0, 0, 0,  0,   0,  1, 0, 0);
        add("dn_tc",        0, 0, 0, 1, 0,  0,   0,  0, 1, 1);
        add("dn_stop",      0, 0, 1, 1, 0,  0,   0,  0, 0, 0);
        // reset mid-count at count=4
        add("rm_start",     0, 1, 0, 0, 0,  6,   6,  1, 0, 0);
        add("rm_t1",        0, 0, 0, 1, 0,  6,   5,  1, 0, 0);
        add("rm_t2",        0, 0, 0, 1, 0,  6,   4,  1, 0, 0);
        add("rm_reset",     1, 1, 0, 1, 0,  6,   0,  0, 0, 0);
        // reset forces a pending tc low
        add("rt_start",     0, 1, 0, 0, 1,  0,   0,  1, 0, 0);
        add("rt_tc",        0, 0, 0, 1, 1,  0,   0,  1, 1, 0);
        add("rt_reset",     1, 0, 0, 1, 1,  0,   0,  0, 0, 0);
        // load 0, periodic: tc on every enabled cycle
        add("z_start",      0, 1, 0, 0, 1,  0,   0,  1, 0, 0);
        add("z_tc1",        0, 0, 0, 1, 1,  0,   0,  1, 1, 0);
        add("z_tc2",        0, 0, 0, 1, 1,  0,   0,  1, 1, 0);
        add("z_tc3",        0, 0, 0, 1, 1,  0,   0,  1, 1, 0);
        add("z_noen",       0, 0, 0, 0, 1,  0,   0,  1, 0, 0);
        add("z_tc4",        0, 0, 0, 1, 1,  0,   0,  1, 1, 0);
        add("z_oneshot",    0, 0, 0, 1, 0,  0,   0,  0, 1, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].e, vecs[i].ar, vecs[i].lv);
            check(vecs[i].name, vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_tc, vecs[i].exp_done);
        end

        // Gated en: load 5, en 1,0,1,0,... -> terminal on the 11th cycle.
        step(0, 1, 0, 0, 0, 5);
        check("gate_start", 5, 1, 0, 0);
        exp_c = 5;
        ticks = 0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            logic e;
            e = (cyc % 2 == 1);
            step(0, 0, 0, e, 0, 5);
            if (e) ticks++;
            if (e && exp_c > 0) exp_c--;
            if (cyc < 11) check("gate_run", W'(exp_c), 1, 0, 0);
            else          check("gate_tc", 0, 0, 1, 1);
        end
        tests_run++;
        if (ticks != 6) begin
            tests_failed++;
            $display("FAIL gate_ticks: got %0d, expected 6", ticks);
        end

        // load 255 one-shot: 256 enabled ticks to tc.
        step(0, 1, 0, 0, 0, 255);
        check("max_start", 255, 1, 0, 0);
        for (int k = 1; k <= 255; k++) begin
            step(0, 0, 0, 1, 0, 255);
            if (k == 1 || k == 128 || k == 255) check("max_run", W'(255 - k), 1, 0, 0);
            else if (tc !== 1'b0) check("max_early_tc", W'(255 - k), 1, 0, 0);
        end
        step(0, 0, 0, 1, 0, 255);
        check("max_tc", 0, 0, 1, 1);
        step(0, 0, 0, 1, 0, 255);
        check("max_after", 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/downward_timer.md
# downward_timer

Programmable down-counting timer, the countdown counterpart of the team's wrapping up-counter. It loads a start value, decrements once per enable tick, and flags terminal count on reaching zero. It then either reloads (periodic mode) or stops (one-shot mode). It sits beside the up-counters in the timing/sequencing fabric and generates timeouts, delays and periodic strobes under control of the higher-level FSMs.

## Interface
- WIDTH, 8, bit width of the counter and the load value.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse: load `load_value` and begin counting; also restarts a running count.
- stop  input  1  pulse: abort counting and return to IDLE.
- en  input  1  tick enable; one decrement per cycle with en=1 while running.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled at each terminal count.
- load_value  input  WIDTH  start/reload value; sampled only on accepted start and on auto-reload.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  high while in RUN (registered).
- tc  output  1  terminal-count strobe, high for exactly one cycle per terminal event.
- done  output  1  sticky one-shot completion flag; cleared by start, stop or reset.

## Operation
- States are IDLE, RUN and DONE.
- Reset sets state=IDLE, count=0, busy=0, tc=0, done=0. Reset overrides every other input.
- Input priority on each edge: reset > stop > start > en.
- IDLE:
  - start → count<=load_value, state RUN, busy<=1.
  - en is ignored.
- RUN, in priority order:
  - stop → state IDLE, busy<=0, count holds its current value, no tc.
  - start → count<=load_value, stay in RUN, no tc. The en of that cycle is ignored.
  - en with count≠0 → count<=count-1.
  - en with count==0 → terminal event: tc<=1 for one cycle.
    - auto_reload=1: count<=load_value (current input value), stay in RUN.
    - auto_reload=0: state DONE, busy<=0, done<=1, count stays 0.
  - en=0 → count holds.
- DONE:
  - count=0, done=1; en is ignored.
  - start → reload, state RUN, done<=0.
  - stop → state IDLE, done<=0.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - The decrement never underflows because zero is always handled as the terminal event.
  - Period is load_value+1 en ticks. This mirrors the up-counter's 0..limit span.
- load_value=0 is legal:
  - One-shot mode: terminal on the first en.
  - Periodic mode: tc on every en cycle.
- tc is never asserted in two consecutive cycles unless en is high in both cycles with load_value=0 in periodic mode.

## Timing
- All outputs are registered and change only on the rising clk edge.
- Start latency: start sampled at edge N → count=load_value and busy=1 visible after edge N.
- Decrement latency: en sampled at edge N → new count visible after edge N.
- Terminal event: en=1 with count==0 at edge N →
  - tc=1 during the cycle after edge N, and deasserted after edge N+1.
  - In one-shot mode, done=1 and busy=0 become visible in the same cycle as tc.
- Stop latency: stop sampled at edge N → busy=0 after edge N; tc cannot assert from that edge.
- Simultaneous stop+start: stop wins, and the block ends in IDLE.
- Simultaneous start+terminal condition: start wins, with no tc and no done.
- Reset mid-count: after the reset edge all outputs are at reset values, including tc forced to 0.

## Test plan
- One-shot: WIDTH=8, load_value=3, auto_reload=0, start pulse, then en held high → count goes 3,2,1,0; tc pulses once on the 4th en; done=1, busy=0; count stays 0 under further en.
- Periodic: load_value=2, auto_reload=1, en continuous for 9 cycles after start → count sequence 2,1,0,2,1,0,2,1,0; tc high 3 times, spaced 3 cycles apart; busy stays 1; done stays 0.
- Gated en: load_value=5, en toggling 1,0,1,0 → count decrements only on en=1 cycles; terminal after 6 enabled ticks (11 cycles).
- Restart and stop: load_value=10, 4 ticks (count=6), then start with load_value=7 → count=7, no tc. Then stop with en=1 in the same cycle → IDLE, count holds at 7, busy=0, no tc.
- Priority and reset: in RUN, assert stop and start together → IDLE. In DONE, a start clears done and reloads. Reset asserted at count=4 → count=0, busy=0, tc=0, done=0 after that edge.
- Edge values: load_value=0 with periodic mode and en continuous → tc high every en cycle, count stays 0. WIDTH=8, load_value=255 one-shot → 256 en ticks to tc.
